// File: rtl/pfe_pkg.sv
// Shared definitions for the prefetch fan-out engine: op field positions,
// saturating add and stats slice indexing.
package pfe_pkg;

   localparam int PFE_TO_DC_BIT   = 0;
   localparam int PFE_TO_L2_BIT   = 1;
   localparam int PFE_DEDUP_CNT_W = 16;

   function automatic int pipe_bits(input int npipe);
      return (npipe > 1) ? $clog2(npipe) : 1;
   endfunction

   // Bit offset of counter k of pipe p inside a packed per-pipe stats bus.
   function automatic int stat_lsb(input int pipe, input int k,
                                   input int stat_w, input int cnt_w);
      return pipe * stat_w + k * cnt_w;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/pfe_chan_fifo.sv
// Per-channel skid FIFO with valid/retry output handshake and a registered
// full flag; push is ignored while full.
module pfe_chan_fifo #(
   parameter int OP_W  = 128,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_push,
   input  logic [OP_W-1:0] i_data,
   output logic            o_full,
   output logic            o_valid,
   input  logic            i_retry,
   output logic [OP_W-1:0] o_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [OP_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = o_valid && !i_retry;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; r_count gates o_valid, so a
   // stale entry is never presented downstream.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/pf_fanout_engine.sv
// Routes prefetch ops to per-pipe DC/L2 request FIFOs and aggregates per-pipe
// stats into saturating totals. Optional duplicate filter: PFE_DEDUP_EN.
module pf_fanout_engine
   import pfe_pkg::*;
#(
   parameter int  NPIPE   = 2,
   parameter int  OP_W    = 128,
   parameter int  SEL_LSB = 8,
   parameter int  DEPTH   = 2,
   parameter int  NCNT    = 7,
   parameter int  CNT_W   = 8,
   localparam int PIPE_B  = pipe_bits(NPIPE),
   localparam int STAT_W  = NCNT * CNT_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pfgtopfe_op_valid,
   output logic                    pfgtopfe_op_retry,
   input  logic [OP_W-1:0]         pfgtopfe_op,
   output logic [NPIPE-1:0]        pftodc_req_valid,
   input  logic [NPIPE-1:0]        pftodc_req_retry,
   output logic [NPIPE*OP_W-1:0]   pftodc_req,
   output logic [NPIPE-1:0]        pftol2_req_valid,
   input  logic [NPIPE-1:0]        pftol2_req_retry,
   output logic [NPIPE*OP_W-1:0]   pftol2_req,
   input  logic [NPIPE*STAT_W-1:0] pfN_dcstats_in,
   input  logic [NPIPE*STAT_W-1:0] pfN_l2stats_in,
   output logic [STAT_W-1:0]       pf_dcstats,
   output logic [STAT_W-1:0]       pf_l2stats
`ifdef PFE_DEDUP_EN
   ,
   output logic [PFE_DEDUP_CNT_W-1:0] pfe_dedup_cnt
`endif
);

   logic [PIPE_B-1:0] w_sel;
   logic              w_to_dc;
   logic              w_to_l2;
   logic [NPIPE-1:0]  w_dc_full;
   logic [NPIPE-1:0]  w_l2_full;
   logic              w_tgt_full;
   logic              w_dup;
   logic              w_accept;
   logic              w_push_ok;
   logic [STAT_W-1:0] w_dc_sum;
   logic [STAT_W-1:0] w_l2_sum;
   logic [STAT_W-1:0] r_dcstats;
   logic [STAT_W-1:0] r_l2stats;

   if (NPIPE == 1) begin : g_sel_one
      assign w_sel = '0;
   end else begin : g_sel_many
      assign w_sel = pfgtopfe_op[SEL_LSB +: PIPE_B];
   end

   assign w_to_dc = pfgtopfe_op[PFE_TO_DC_BIT];
   assign w_to_l2 = pfgtopfe_op[PFE_TO_L2_BIT];

   // Full flags are registered, so retry never sees a same-cycle pop.
   assign w_tgt_full        = (w_to_dc && w_dc_full[w_sel]) || (w_to_l2 && w_l2_full[w_sel]);
   assign w_accept          = pfgtopfe_op_valid && (w_dup || !w_tgt_full);
   assign w_push_ok         = w_accept && !w_dup;
   assign pfgtopfe_op_retry = pfgtopfe_op_valid && !w_accept;

   for (genvar gi = 0; gi < NPIPE; gi++) begin : g_pipe
      logic w_dc_push;
      logic w_l2_push;

      assign w_dc_push = w_push_ok && w_to_dc && (w_sel == PIPE_B'(gi));
      assign w_l2_push = w_push_ok && w_to_l2 && (w_sel == PIPE_B'(gi));

      pfe_chan_fifo #(.OP_W(OP_W), .DEPTH(DEPTH)) u_dc_fifo (
         .clk     (clk),
         .reset   (reset),
         .i_push  (w_dc_push),
         .i_data  (pfgtopfe_op),
         .o_full  (w_dc_full[gi]),
         .o_valid (pftodc_req_valid[gi]),
         .i_retry (pftodc_req_retry[gi]),
         .o_data  (pftodc_req[gi*OP_W +: OP_W])
      );

      pfe_chan_fifo #(.OP_W(OP_W), .DEPTH(DEPTH)) u_l2_fifo (
         .clk     (clk),
         .reset   (reset),
         .i_push  (w_l2_push),
         .i_data  (pfgtopfe_op),
         .o_full  (w_l2_full[gi]),
         .o_valid (pftol2_req_valid[gi]),
         .i_retry (pftol2_req_retry[gi]),
         .o_data  (pftol2_req[gi*OP_W +: OP_W])
      );
   end

`ifdef PFE_DEDUP_EN
   localparam int KEY_W = OP_W - SEL_LSB;

   logic [KEY_W-1:0]           r_last_key [NPIPE];
   logic [NPIPE-1:0]           r_last_vld;
   logic [PFE_DEDUP_CNT_W-1:0] r_dedup_cnt;

   assign w_dup = pfgtopfe_op_valid && r_last_vld[w_sel] &&
                  (r_last_key[w_sel] == pfgtopfe_op[OP_W-1:SEL_LSB]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_vld  <= '0;
         r_dedup_cnt <= '0;
      end else begin
         if (w_accept) r_last_vld[w_sel] <= 1'b1;
         if (w_dup && (r_dedup_cnt != '1)) r_dedup_cnt <= r_dedup_cnt + PFE_DEDUP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_last_key[w_sel] <= pfgtopfe_op[OP_W-1:SEL_LSB];
   end

   assign pfe_dedup_cnt = r_dedup_cnt;
`else
   assign w_dup = 1'b0;
`endif

   // Saturating at every step gives the same result as clamping the full
   // CNT_W+PIPE_B-bit sum, because all addends are non-negative.
   always_comb begin
      // NOTE: defaults first so every path assigns the sums and no latch forms.
      w_dc_sum = '0;
      w_l2_sum = '0;
      for (int k = 0; k < NCNT; k++) begin
         for (int i = 0; i < NPIPE; i++) begin
            w_dc_sum[k*CNT_W +: CNT_W] = CNT_W'(sat_add(
               32'(w_dc_sum[k*CNT_W +: CNT_W]),
               32'(pfN_dcstats_in[stat_lsb(i, k, STAT_W, CNT_W) +: CNT_W]), CNT_W));
            w_l2_sum[k*CNT_W +: CNT_W] = CNT_W'(sat_add(
               32'(w_l2_sum[k*CNT_W +: CNT_W]),
               32'(pfN_l2stats_in[stat_lsb(i, k, STAT_W, CNT_W) +: CNT_W]), CNT_W));
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dcstats <= '0;
         r_l2stats <= '0;
      end else begin
         r_dcstats <= w_dc_sum;
         r_l2stats <= w_l2_sum;
      end
   end

   assign pf_dcstats = r_dcstats;
   assign pf_l2stats = r_l2stats;

endmodule

// File: tb/tb_pf_fanout_engine.sv
// Directed bench for pf_fanout_engine at NPIPE=4, DEPTH=2, CNT_W=8.
module tb_pf_fanout_engine;

   localparam int NPIPE   = 4;
   localparam int OP_W    = 128;
   localparam int SEL_LSB = 8;
   localparam int DEPTH   = 2;
   localparam int NCNT    = 7;
   localparam int CNT_W   = 8;
   localparam int STAT_W  = NCNT * CNT_W;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    op_valid;
   logic                    op_retry;
   logic [OP_W-1:0]         op;
   logic [NPIPE-1:0]        dc_valid, dc_retry, l2_valid, l2_retry;
   logic [NPIPE*OP_W-1:0]   dc_req, l2_req;
   logic [NPIPE*STAT_W-1:0] dc_stats_in, l2_stats_in;
   logic [STAT_W-1:0]       dc_stats, l2_stats;
`ifdef PFE_DEDUP_EN
   logic [15:0]             dedup_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pf_fanout_engine #(
      .NPIPE(NPIPE), .OP_W(OP_W), .SEL_LSB(SEL_LSB),
      .DEPTH(DEPTH), .NCNT(NCNT), .CNT_W(CNT_W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pfgtopfe_op_valid (op_valid),
      .pfgtopfe_op_retry (op_retry),
      .pfgtopfe_op       (op),
      .pftodc_req_valid  (dc_valid),
      .pftodc_req_retry  (dc_retry),
      .pftodc_req        (dc_req),
      .pftol2_req_valid  (l2_valid),
      .pftol2_req_retry  (l2_retry),
      .pftol2_req        (l2_req),
      .pfN_dcstats_in    (dc_stats_in),
      .pfN_l2stats_in    (l2_stats_in),
      .pf_dcstats        (dc_stats),
      .pf_l2stats        (l2_stats)
`ifdef PFE_DEDUP_EN
      ,
      .pfe_dedup_cnt     (dedup_cnt)
`endif
   );

   function automatic logic [OP_W-1:0] mk_op(input logic [31:0] tag, input int sel,
                                             input bit to_dc, input bit to_l2);
      logic [OP_W-1:0] v;
      v = '0;
      v[OP_W-1 -: 32] = tag;
      v[40 +: 16]     = 16'hBEEF ^ tag[15:0];
      v[SEL_LSB +: 2] = 2'(sel);
      v[0]            = to_dc;
      v[1]            = to_l2;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      op_valid    = 1'b1;
      op          = mk_op(32'h1, 1, 1'b1, 1'b1);
      dc_stats_in = '1;
      l2_stats_in = '1;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (dc_valid !== 4'b0000) begin errors++; $display("FAIL reset_dc_valid got %b want 0000", dc_valid); end
      checks++; if (l2_valid !== 4'b0000) begin errors++; $display("FAIL reset_l2_valid got %b want 0000", l2_valid); end
      checks++; if (op_retry !== 1'b0) begin errors++; $display("FAIL reset_retry got %b want 0", op_retry); end
      checks++; if (dc_stats !== '0) begin errors++; $display("FAIL reset_dcstats got %h want 0", dc_stats); end
      checks++; if (l2_stats !== '0) begin errors++; $display("FAIL reset_l2stats got %h want 0", l2_stats); end
      op_valid    = 1'b0;
      dc_stats_in = '0;
      l2_stats_in = '0;
      reset       = 1'b0;
      tick();
   endtask

   task automatic test_route();
      logic [OP_W-1:0] a;
      a        = mk_op(32'h100, 2, 1'b1, 1'b1);
      op       = a;
      op_valid = 1'b1;
      #1;
      checks++; if (op_retry !== 1'b0) begin errors++; $display("FAIL route_retry got %b want 0", op_retry); end
      checks++; if (dc_valid !== 4'b0000) begin errors++; $display("FAIL route_no_bypass got %b want 0000", dc_valid); end
      tick();
      op_valid = 1'b0;
      checks++; if (dc_valid !== 4'b0100) begin errors++; $display("FAIL route_dc_valid got %b want 0100", dc_valid); end
      checks++; if (l2_valid !== 4'b0100) begin errors++; $display("FAIL route_l2_valid got %b want 0100", l2_valid); end
      checks++; if (dc_req[2*OP_W +: OP_W] !== a) begin errors++; $display("FAIL route_dc_data got %h want %h", dc_req[2*OP_W +: OP_W], a); end
      checks++; if (l2_req[2*OP_W +: OP_W] !== a) begin errors++; $display("FAIL route_l2_data got %h want %h", l2_req[2*OP_W +: OP_W], a); end
      tick();
      checks++; if ({dc_valid, l2_valid} !== 8'h00) begin errors++; $display("FAIL route_drain got %b want 0", {dc_valid, l2_valid}); end
   endtask

   task automatic test_backpressure();
      logic [OP_W-1:0] a, b, c;
      a        = mk_op(32'h201, 1, 1'b1, 1'b0);
      b        = mk_op(32'h202, 1, 1'b1, 1'b0);
      c        = mk_op(32'h203, 1, 1'b1, 1'b0);
      dc_retry = 4'b0010;
      op = a; op_valid = 1'b1; #1;
      checks++; if (op_retry !== 1'b0) begin errors++; $display("FAIL bp_a_retry got %b want 0", op_retry); end
      tick();
      op = b; #1;
      checks++; if (op_retry !== 1'b0) begin errors++; $display("FAIL bp_b_retry got %b want 0", op_retry); end
      tick();
      op = c; #1;
      checks++; if (op_retry !== 1'b1) begin errors++; $display("FAIL bp_c_retry_full got %b want 1", op_retry); end
      tick();
      checks++; if (op_retry !== 1'b1) begin errors++; $display("FAIL bp_c_retry_hold got %b want 1", op_retry); end
      checks++; if (dc_req[OP_W +: OP_W] !== a) begin errors++; $display("FAIL bp_head_a got %h want %h", dc_req[OP_W +: OP_W], a); end
      dc_retry = 4'b0000; #1;
      checks++; if (op_retry !== 1'b1) begin errors++; $display("FAIL bp_no_comb_path got %b want 1", op_retry); end
      tick();
      dc_retry = 4'b0010; #1;
      checks++; if (op_retry !== 1'b0) begin errors++; $display("FAIL bp_c_after_pop got %b want 0", op_retry); end
      checks++; if (dc_req[OP_W +: OP_W] !== b) begin errors++; $display("FAIL bp_head_b got %h want %h", dc_req[OP_W +: OP_W], b); end
      tick();
      op_valid = 1'b0;
      checks++; if (dc_req[OP_W +: OP_W] !== b) begin errors++; $display("FAIL bp_hold_b got %h want %h", dc_req[OP_W +: OP_W], b); end
      dc_retry = 4'b0000;
      tick();
      checks++; if (dc_req[OP_W +: OP_W] !== c || dc_valid !== 4'b0010) begin errors++; $display("FAIL bp_head_c got %h/%b want %h/0010", dc_req[OP_W +: OP_W], dc_valid, c); end
      tick();
      checks++; if (dc_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain got %b want 0000", dc_valid); end
   endtask

   task automatic test_atomic();
      logic [OP_W-1:0] l0, l1, both, none;
      l0       = mk_op(32'h301, 0, 1'b0, 1'b1);
      l1       = mk_op(32'h302, 0, 1'b0, 1'b1);
      both     = mk_op(32'h303, 0, 1'b1, 1'b1);
      none     = mk_op(32'h304, 0, 1'b0, 1'b0);
      l2_retry = 4'b0001;
      op = l0; op_valid = 1'b1; tick();
      op = l1; tick();
      op = both; #1;
      checks++; if (op_retry !== 1'b1) begin errors++; $display("FAIL atomic_retry got %b want 1", op_retry); end
      tick();
      checks++; if (dc_valid !== 4'b0000) begin errors++; $display("FAIL atomic_dc_empty got %b want 0000", dc_valid); end
      op = none; #1;
      checks++; if (op_retry !== 1'b0) begin errors++; $display("FAIL empty_target_retry got %b want 0", op_retry); end
      tick();
      op_valid = 1'b0;
      checks++; if (dc_valid !== 4'b0000 || l2_valid !== 4'b0001) begin errors++; $display("FAIL empty_target_drop got %b/%b want 0000/0001", dc_valid, l2_valid); end
      checks++; if (l2_req[0 +: OP_W] !== l0) begin errors++; $display("FAIL atomic_l2_order got %h want %h", l2_req[0 +: OP_W], l0); end
      l2_retry = 4'b0000;
      tick();
      checks++; if (l2_req[0 +: OP_W] !== l1) begin errors++; $display("FAIL atomic_l2_second got %h want %h", l2_req[0 +: OP_W], l1); end
      tick();
      checks++; if (l2_valid !== 4'b0000) begin errors++; $display("FAIL atomic_drain got %b want 0000", l2_valid); end
   endtask

   task automatic test_stats();
      dc_stats_in = '0;
      l2_stats_in = '0;
      dc_stats_in[0*STAT_W + 0*CNT_W +: CNT_W] = 8'd200;
      dc_stats_in[1*STAT_W + 0*CNT_W +: CNT_W] = 8'd100;
      for (int i = 0; i < NPIPE; i++) begin
         l2_stats_in[i*STAT_W + 6*CNT_W +: CNT_W] = 8'(10 * (i + 1));
         l2_stats_in[i*STAT_W + 3*CNT_W +: CNT_W] = 8'd255;
      end
      #1;
      checks++; if (dc_stats !== '0) begin errors++; $display("FAIL stats_latency got %h want 0", dc_stats); end
      tick();
      checks++; if (dc_stats !== 56'h000000000000FF) begin errors++; $display("FAIL stats_dc_sat got %h want 000000000000ff", dc_stats); end
      checks++; if (l2_stats !== 56'h640000FF000000) begin errors++; $display("FAIL stats_l2_mix got %h want 640000ff000000", l2_stats); end
      dc_stats_in = '0;
      l2_stats_in = '0;
      dc_stats_in[0*STAT_W + 0*CNT_W +: CNT_W] = 8'd3;
      dc_stats_in[1*STAT_W + 0*CNT_W +: CNT_W] = 8'd4;
      dc_stats_in[2*STAT_W + 5*CNT_W +: CNT_W] = 8'd1;
      dc_stats_in[3*STAT_W + 5*CNT_W +: CNT_W] = 8'd254;
      tick();
      checks++; if (dc_stats !== 56'h00FF0000000007) begin errors++; $display("FAIL stats_dc_sum got %h want 00ff0000000007", dc_stats); end
      checks++; if (l2_stats !== '0) begin errors++; $display("FAIL stats_l2_zero got %h want 0", l2_stats); end
      dc_stats_in = '0;
   endtask

   task automatic test_reset_midflight();
      logic [OP_W-1:0] d1, d2, d3;
      bit              seen;
      d1       = mk_op(32'h401, 3, 1'b1, 1'b0);
      d2       = mk_op(32'h402, 3, 1'b1, 1'b0);
      d3       = mk_op(32'h403, 3, 1'b1, 1'b0);
      dc_retry = 4'b1000;
      op = d1; op_valid = 1'b1; tick();
      op = d2; tick();
      op_valid = 1'b0;
      checks++; if (dc_valid !== 4'b1000) begin errors++; $display("FAIL mid_queued got %b want 1000", dc_valid); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if ({dc_valid, l2_valid} !== 8'h00) begin errors++; $display("FAIL mid_async_drop got %b want 0", {dc_valid, l2_valid}); end
      tick();
      dc_retry = 4'b0000;
      reset    = 1'b0;
      seen     = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         if ({dc_valid, l2_valid} !== 8'h00) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_ghost got %b want 0", seen); end
      op = d3; op_valid = 1'b1; tick();
      op_valid = 1'b0;
      checks++; if (dc_valid !== 4'b1000 || dc_req[3*OP_W +: OP_W] !== d3) begin errors++; $display("FAIL mid_new_op got %b/%h want 1000/%h", dc_valid, dc_req[3*OP_W +: OP_W], d3); end
      tick();
      checks++; if (dc_valid !== 4'b0000) begin errors++; $display("FAIL mid_drain got %b want 0000", dc_valid); end
   endtask

`ifdef PFE_DEDUP_EN
   task automatic test_dedup();
      logic [OP_W-1:0] e;
      e  = mk_op(32'h501, 0, 1'b1, 1'b0);
      op = e; op_valid = 1'b1; #1;
      checks++; if (op_retry !== 1'b0) begin errors++; $display("FAIL dedup_first_retry got %b want 0", op_retry); end
      tick();
      checks++; if (op_retry !== 1'b0) begin errors++; $display("FAIL dedup_second_retry got %b want 0", op_retry); end
      checks++; if (dc_valid !== 4'b0001 || dc_req[0 +: OP_W] !== e) begin errors++; $display("FAIL dedup_first_out got %b/%h want 0001/%h", dc_valid, dc_req[0 +: OP_W], e); end
      tick();
      op_valid = 1'b0;
      checks++; if (dc_valid !== 4'b0000) begin errors++; $display("FAIL dedup_dropped got %b want 0000", dc_valid); end
      checks++; if (dedup_cnt !== 16'd1) begin errors++; $display("FAIL dedup_cnt got %0d want 1", dedup_cnt); end
   endtask
`endif

   initial begin
      reset       = 1'b1;
      op_valid    = 1'b0;
      op          = '0;
      dc_retry    = '0;
      l2_retry    = '0;
      dc_stats_in = '0;
      l2_stats_in = '0;
      test_reset();
      test_route();
      test_backpressure();
      test_atomic();
      test_stats();
      test_reset_midflight();
`ifdef PFE_DEDUP_EN
      test_dedup();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pf_fanout_engine.md
Name: pf_fanout_engine

Overview:
- Parametrised successor to the prefetch engine. Takes prefetch ops from the prefetch generator and routes each one to the DC and/or L2 request channel of a single pipe.
- The pipe is chosen from the op's address bits. Each output channel has its own skid FIFO, so one stalled cache does not block the others.
- Also aggregates the per-pipe DC and L2 prefetch statistics into saturating totals, replacing the old pipe-0 pass-through.
- Sits between the prefetch generator and the per-pipe DC/L2 prefetch ports.

Parameters:
- NPIPE, 2, number of pipes (1, 2 or 4); PIPE_B = max(1, clog2(NPIPE)).
- OP_W, 128, width of the prefetch op and of each cache request.
- SEL_LSB, 8, lowest op bit of the pipe-select field op[SEL_LSB +: PIPE_B].
- DEPTH, 2, entries per output FIFO (power of two, at least 2).
- NCNT, 7, counters per stats word.
- CNT_W, 8, width of each counter; stats word width STAT_W = NCNT*CNT_W (56 at defaults).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pfgtopfe_op_valid  in  1  input op valid.
- pfgtopfe_op_retry  out  1  input op retry.
- pfgtopfe_op  in  OP_W  op: bit0 = to_dc, bit1 = to_l2, remaining bits are the address/payload.
- pftodc_req_valid  out  NPIPE  per-pipe DC request valid.
- pftodc_req_retry  in  NPIPE  per-pipe DC request retry.
- pftodc_req  out  NPIPE*OP_W  DC requests; pipe i occupies slice [i*OP_W +: OP_W].
- pftol2_req_valid, pftol2_req_retry, pftol2_req  same as the DC group, for L2.
- pfN_dcstats_in  in  NPIPE*STAT_W  per-pipe DC stats.
- pfN_l2stats_in  in  NPIPE*STAT_W  per-pipe L2 stats.
- pf_dcstats  out  STAT_W  aggregated DC stats (flop state, no handshake).
- pf_l2stats  out  STAT_W  aggregated L2 stats (flop state, no handshake).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All state clears on reset: FIFOs empty, all req_valid = 0, pf_dcstats = pf_l2stats = 0, pfgtopfe_op_retry = 0.
- Routing: p = op[SEL_LSB +: PIPE_B]. With NPIPE = 1, p = 0.
  - Target set = {dc[p] if to_dc} ∪ {l2[p] if to_l2}.
  - NPIPE = 2: only the low select bit is used.
- Accept: the op is accepted when valid and every FIFO in the target set is not full. Acceptance is atomic: the op is pushed into all targets in the same cycle or into none.
- Retry: pfgtopfe_op_retry = valid && !accept.
  - Retry depends only on registered FIFO state. There is no combinational path from any *_req_retry input.
  - A pop in the same cycle does not free space until the next cycle.
- Empty target set (to_dc = to_l2 = 0): the op is accepted and dropped with no retry.
- Latency: a pushed op appears on the req output the cycle after acceptance, at the earliest. There is no bypass.
- Output handshake: req_valid = FIFO not empty. Pop when valid && !retry. Data is held stable while retry is asserted.
- FIFO: circular buffer with wrapping rd/wr pointers plus a count of clog2(DEPTH)+1 bits. Push and pop in the same cycle are legal on a non-full FIFO; on a full FIFO the push is refused. Order is FIFO per channel. No ordering is guaranteed across channels.
- Stats, each cycle:
  - pf_dcstats counter k <= saturating sum over pipes i of the counter-k slice of pfN_dcstats_in[i*STAT_W + k*CNT_W +: CNT_W].
  - The sum is computed at CNT_W + PIPE_B bits and clamps to all-ones on overflow.
  - The same applies to L2. Output latency is 1 cycle.
- Reset asserted mid-transfer: queued ops are lost, valids drop immediately (asynchronously), and no partial ops are emitted after reset.

Optional Feature:
- Macro: PFE_DEDUP_EN.
- With the macro defined:
  - Each pipe keeps the last accepted op (bits above SEL_LSB, with to_dc/to_l2 masked off) plus a valid bit, cleared on reset.
  - An op matching its pipe's last op is accepted and dropped: no push, no retry.
  - Extra output pfe_dedup_cnt (16 bits) counts drops, saturating at 0xFFFF, and resets to 0.
- Without the macro: no filter, and the pfe_dedup_cnt port is absent.

Decomposition:
- Shared package pfe_pkg: field constants (PFE_TO_DC_BIT = 0, PFE_TO_L2_BIT = 1), the sat_add function, and the stats slice-index helpers.
- Sub-module pfe_chan_fifo (OP_W, DEPTH) provides the valid/retry FIFO with a full flag. It is instantiated 2*NPIPE times via generate.

Test Plan:
- NPIPE = 4, op with to_dc = 1, to_l2 = 1, select = 2, retries low -> pftodc_req_valid = 4'b0100 and pftol2_req_valid = 4'b0100 the next cycle, data equals the op, other channels idle.
- Hold pftodc_req_retry[1] = 1 and send 3 dc-only ops to pipe 1 with DEPTH = 2 -> first two accepted, third sees retry = 1 until one pop, then accepted one cycle after the pop.
- L2 FIFO of pipe 0 full, op with to_dc = 1, to_l2 = 1 to pipe 0 -> retry = 1, and the DC FIFO of pipe 0 receives nothing (atomicity).
- Stats: NPIPE = 2, CNT_W = 8, counter 0 inputs 200 and 100 -> pf_dcstats[7:0] = 255 one cycle later; inputs 3 and 4 -> 7.
- Assert reset with 2 ops queued -> all req_valid = 0 immediately; after release no valid is raised until a new op arrives.
- PFE_DEDUP_EN: the same dc op to pipe 0 twice back-to-back -> one request emitted, pfe_dedup_cnt = 1.
